// File: rtl/pulse_gen.sv
// rtl/pulse_gen.sv - pulse-width link transmitter: handshaked length code to single-wire pulse
//
// Optional feature macro: PULSE_GEN_ABORT_EN (adds the abort input)
//
// Parameters:
//   W    width of data and of the pulse down-counter
//   GAP  minimum low cycles between pulses (1..255)
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset
//   valid  in   request strobe qualifying data
//   data   in   pulse length code, high time = data+1 cycles
//   ready  out  request accepted on an edge where valid & ready
//   out    out  registered pulse line
//   busy   out  pulse or gap in progress, or a request is held
//   done   out  one-cycle strobe in the first low cycle after a pulse
//   abort  in   (PULSE_GEN_ABORT_EN only) cut the pulse, drop the held request
module pulse_gen #(
    parameter int W   = 11,
    parameter int GAP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [W-1:0] data,
`ifdef PULSE_GEN_ABORT_EN
    input  logic         abort,
`endif
    output logic         ready,
    output logic         out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [7:0]   gap_q, gap_d;
    logic [W-1:0] hold_q, hold_d;
    logic         hold_full_q, hold_full_d;
    logic         out_q, out_d;
    logic         done_q, done_d;
    logic         accept;

    // ready comes from a register only, so it never combinationally follows valid.
    assign ready = ~hold_full_q;
    assign out   = out_q;
    assign done  = done_q;
    assign busy  = (state_q != ST_IDLE) | hold_full_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        out_d       = out_q;
        done_d      = 1'b0;
        accept      = valid & ~hold_full_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_PULSE;
                    out_d   = 1'b1;
                    cnt_d   = data;
                end
            end
            ST_PULSE: begin
                if (accept) begin
                    hold_d      = data;
                    hold_full_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    out_d   = 1'b0;
                    done_d  = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                    if (accept) begin
                        hold_d      = data;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    state_d     = ST_PULSE;
                    out_d       = 1'b1;
                    cnt_d       = hold_q;
                    hold_full_d = 1'b0;
                end else if (accept) begin
                    // Gap already satisfied: start straight away instead of
                    // parking the request in the hold register.
                    state_d = ST_PULSE;
                    out_d   = 1'b1;
                    cnt_d   = data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                out_d   = 1'b0;
            end
        endcase

`ifdef PULSE_GEN_ABORT_EN
        // Abort overrides everything above, including an accept on this edge.
        if (abort) begin
            state_d     = ST_IDLE;
            out_d       = 1'b0;
            done_d      = 1'b0;
            hold_full_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gap_q       <= 8'd0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            out_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            out_q       <= out_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_pulse_gen.sv
// tb/tb_pulse_gen.sv - self-checking bench for pulse_gen with a timeline reference model
module tb_pulse_gen;

    localparam int W   = 11;
    localparam int GAP = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic [W-1:0] data;
    logic         ready;
    logic         out;
    logic         busy;
    logic         done;
`ifdef PULSE_GEN_ABORT_EN
    logic         abort;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: pulses live on an edge timeline. A pulse started at
    // edge s with code L is high after edges s..s+L, done after edge s+L+1,
    // and the next pulse may start no earlier than edge s+L+1+GAP.
    int k;
    bit m_hold_full;
    int m_hold;
    int cur_start, cur_end, done_edge, free_edge;
    bit e_out, e_done, e_busy, e_ready;

    bit tr_out[$];
    bit tr_done[$];
    bit tr_busy[$];
    bit tr_ready[$];

    pulse_gen #(.W(W), .GAP(GAP)) dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .data  (data),
`ifdef PULSE_GEN_ABORT_EN
        .abort (abort),
`endif
        .ready (ready),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold_full = 1'b0;
        m_hold      = 0;
        cur_start   = -100;
        cur_end     = -101;
        done_edge   = -100;
        free_edge   = k;
    endtask

    task automatic model_start(input int len);
        cur_start = k;
        cur_end   = k + len;
        done_edge = k + len + 1;
        free_edge = k + len + 1 + GAP;
    endtask

    task automatic model_edge(input bit v, input int d, input bit ab);
        bit acc;
        acc = v && !m_hold_full;
        if (ab) begin
            m_hold_full = 1'b0;
            if (cur_end >= k) cur_end = k - 1;
            done_edge = -100;
            free_edge = k;
        end else if (k >= free_edge) begin
            if (m_hold_full) begin
                model_start(m_hold);
                m_hold_full = 1'b0;
            end else if (acc) begin
                model_start(d);
            end
        end else if (acc) begin
            m_hold      = d;
            m_hold_full = 1'b1;
        end
        e_out   = (k >= cur_start) && (k <= cur_end);
        e_done  = (k == done_edge);
        e_busy  = m_hold_full || (k < free_edge);
        e_ready = !m_hold_full;
        k++;
    endtask

    task automatic step(input bit v, input int d, input bit ab = 1'b0);
        valid = v;
        data  = W'(d);
`ifdef PULSE_GEN_ABORT_EN
        abort = ab;
`endif
        model_edge(v, d, ab);
        @(posedge clk);
        #1;
        chk("out", 32'(out), 32'(e_out));
        chk("done", 32'(done), 32'(e_done));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("ready", 32'(ready), 32'(e_ready));
        tr_out.push_back(out);
        tr_done.push_back(done);
        tr_busy.push_back(busy);
        tr_ready.push_back(ready);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    task automatic clear_trace();
        tr_out.delete();
        tr_done.delete();
        tr_busy.delete();
        tr_ready.delete();
    endtask

    function automatic int ones(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(tr_out[i]);
        return n;
    endfunction

    // Reset asserted mid-cycle; outputs must drop without waiting for a clock edge.
    task automatic do_reset();
        valid = 1'b0;
`ifdef PULSE_GEN_ABORT_EN
        abort = 1'b0;
`endif
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_out", 32'(out), 32'd0);
        chk("rst_async_ready", 32'(ready), 32'd1);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        rst   = 1'b0;
        valid = 1'b0;
        data  = '0;
`ifdef PULSE_GEN_ABORT_EN
        abort = 1'b0;
`endif
        k = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b1;

        // T1: data=0 -> single high cycle, done right after, idle after the gap
        clear_trace();
        step(1'b1, 0);
        idle(3);
        chk("t1_out", 32'({tr_out[0], tr_out[1], tr_out[2], tr_out[3]}), 32'b1000);
        chk("t1_done", 32'({tr_done[0], tr_done[1], tr_done[2], tr_done[3]}), 32'b0100);
        chk("t1_busy", 32'({tr_busy[0], tr_busy[1], tr_busy[2], tr_busy[3]}), 32'b1100);

        // T2: data=5 -> six high cycles
        clear_trace();
        step(1'b1, 5);
        idle(8);
        chk("t2_high", 32'(ones(0, 8)), 32'd6);
        chk("t2_last_high", 32'(tr_out[5]), 32'd1);
        chk("t2_done", 32'(tr_done[6]), 32'd1);

        // T3: 3 then 7 while busy -> 4 high, 1 low, 8 high
        clear_trace();
        step(1'b1, 3);
        step(1'b1, 7);
        idle(14);
        chk("t3_first", 32'(ones(0, 3)), 32'd4);
        chk("t3_gap", 32'(tr_out[4]), 32'd0);
        chk("t3_second", 32'(ones(5, 12)), 32'd8);
        chk("t3_end", 32'(tr_out[13]), 32'd0);
        chk("t3_ready_full", 32'(tr_ready[1]), 32'd0);
        chk("t3_ready_drain", 32'(tr_ready[5]), 32'd1);

        // T4: third request stalls while the hold register is full
        clear_trace();
        step(1'b1, 3);
        step(1'b1, 7);
        for (int i = 0; i < 5; i++) step(1'b1, 9);
        idle(20);
        chk("t4_stall_ready", 32'(tr_ready[3]), 32'd0);
        chk("t4_accept_ready", 32'(tr_ready[6]), 32'd0);
        chk("t4_third_start", 32'(tr_out[14]), 32'd1);
        chk("t4_third_len", 32'(ones(14, 24)), 32'd10);
        chk("t4_idle_busy", 32'(tr_busy[26]), 32'd0);

        // T5: reset in the third high cycle of a data=10 pulse with hold full
        step(1'b1, 10);
        step(1'b1, 4);
        step(1'b0, 0);
        do_reset();
        clear_trace();
        idle(3);
        chk("t5_out", 32'(ones(0, 2)), 32'd0);
        chk("t5_ready", 32'(tr_ready[0]), 32'd1);
        chk("t5_busy", 32'(tr_busy[2]), 32'd0);
        step(1'b1, 2);
        idle(5);

`ifdef PULSE_GEN_ABORT_EN
        // T6: abort during a data=20 pulse with hold full
        clear_trace();
        step(1'b1, 20);
        step(1'b1, 4);
        idle(3);
        step(1'b0, 0, 1'b1);
        idle(2);
        chk("t6_out", 32'(tr_out[5]), 32'd0);
        chk("t6_done", 32'(tr_done[5] | tr_done[6]), 32'd0);
        chk("t6_busy", 32'(tr_busy[5]), 32'd0);
        step(1'b1, 2);
        chk("t6_restart", 32'(out), 32'd1);
        idle(5);
`endif

        // Largest code: 2^W high cycles without wrapping
        clear_trace();
        step(1'b1, 2047);
        idle(2050);
        chk("max_high", 32'(ones(0, 2050)), 32'd2048);
        chk("max_end", 32'(tr_out[2048]), 32'd0);
        chk("max_done", 32'(tr_done[2048]), 32'd1);

        // Randomized traffic, occasional async reset (and abort when built in)
        for (int i = 0; i < 4000; i++) begin
            int r;
            int d;
            bit ab;
            r  = int'($urandom_range(0, 999));
            d  = (r < 20) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 12));
            ab = 1'b0;
`ifdef PULSE_GEN_ABORT_EN
            ab = ($urandom_range(0, 59) == 0);
`endif
            if (r >= 997) do_reset();
            else step($urandom_range(0, 2) == 0, d, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
